priority_decoder: RTL and testbench
===================================

PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 Parameter HOLD, default 4, number of cycles a decoded output is held asserted (legal 1..15).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 W  input  1  code bit 1 (MSB), sampled only when V=1.
REQ-005 Y  input  1  code bit 0 (LSB), sampled only when V=1.
REQ-006 V  input  1  code valid; a code is accepted on a rising edge where V=1 and RDY=1.
REQ-007 A  output  1  one-hot output for code 11.
REQ-008 B  output  1  one-hot output for code 10.
REQ-009 C  output  1  one-hot output for code 01.
REQ-010 D  output  1  one-hot output for code 00.
REQ-011 RDY  output  1  decoder can accept a code this cycle.
REQ-012 BUSY  output  1  a decoded output is currently asserted.
REQ-013 CNT  output  8  accepted-code count (present only with PRIORITY_DECODER_COUNT_EN).

Function
REQ-014 States IDLE and HOLD only; 2-bit code register; 4-bit hold counter.
REQ-015 IDLE: A..D=0, BUSY=0, RDY=1; on acceptance, latch {W,Y}, load counter with HOLD-1, enter HOLD.
REQ-016 HOLD: exactly one of A..D = 1 per latched code (11->A, 10->B, 01->C, 00->D); BUSY=1; counter decrements each cycle.
REQ-017 Outputs A..D and BUSY are registered: asserted the first edge after acceptance, for exactly HOLD cycles.
REQ-018 RDY is combinational: 1 in IDLE, or in HOLD when counter=0 (last hold cycle); 0 otherwise.
REQ-019 Acceptance on the last hold cycle reloads the code and counter and stays in HOLD: back-to-back codes yield contiguous outputs, no idle gap.
REQ-020 Back-to-back identical codes keep the same output high continuously for 2*HOLD cycles.
REQ-021 V=1 while RDY=0 is ignored; code is not queued; W,Y are don't-care when V=0.
REQ-022 No acceptance on the last hold cycle -> return to IDLE; outputs drop the next edge.
REQ-023 HOLD=1: every cycle in HOLD is last; continuous V=1 gives one new code per cycle.
REQ-024 A..D never have more than one bit set in any cycle, including transitions.

Reset
REQ-025 RST=1 immediately forces IDLE, A..D=0, BUSY=0, counter=0, code register=00, CNT=0, regardless of CLK.
REQ-026 RST asserted mid-HOLD aborts the pulse; the in-flight code is discarded.
REQ-027 First acceptance is possible on the first rising edge after RST deasserts.

Configuration
REQ-028 Macro PRIORITY_DECODER_COUNT_EN defined: CNT port and an 8-bit counter exist, incrementing by 1 per acceptance and saturating at 255.
REQ-029 Macro undefined: no CNT port, no counter logic; all other behaviour identical.

Structure
REQ-030 Package priority_pkg holds code constants CODE_A=11, CODE_B=10, CODE_C=01, CODE_D=00 and the IDLE/HOLD state type; shared with the encoder bench.
REQ-031 One sub-module, hold_counter (load, decrement, zero flag, width 4), instantiated once; decode and FSM stay in priority_decoder.

Verification
REQ-032 Reset: RST=1 mid-HOLD on code 11 -> A drops without a clock edge; RDY=1, BUSY=0 after release.
REQ-033 Single code: HOLD=4, V=1 with {W,Y}=00 for one cycle -> D=1 for exactly 4 cycles starting next edge, then IDLE.
REQ-034 Back-to-back: HOLD=4, code 10 then code 01 presented on the last hold cycle -> B for 4 cycles, then C for 4, no gap, never both.
REQ-035 Ignore: V=1 with code 11 while BUSY and counter>0 -> no output change; code 11 never appears.
REQ-036 HOLD=1 stream: V=1 continuously with codes 00,01,10,11 -> D,C,B,A one cycle each, consecutive.
REQ-037 Count (macro defined): 300 accepted codes -> CNT=255; after RST, CNT=0.

Source files
------------

// File: rtl/priority_decoder_pkg.sv
// Shared types and constants for the priority decoder and its encoder bench.
// Package priority_pkg: code constants, FSM state type, one-hot decode helper.
package priority_pkg;

    localparam logic [1:0] CODE_A = 2'b11;
    localparam logic [1:0] CODE_B = 2'b10;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_D = 2'b00;

    localparam int HOLD_W = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Returns {A,B,C,D}; exactly one bit set for any code.
    function automatic logic [3:0] decode(input logic [1:0] code);
        logic [3:0] onehot;
        onehot = 4'b0000;
        unique case (code)
            CODE_A:  onehot = 4'b1000;
            CODE_B:  onehot = 4'b0100;
            CODE_C:  onehot = 4'b0010;
            CODE_D:  onehot = 4'b0001;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/priority_decoder_if.sv
// Code-in / one-hot-out bus of the priority decoder.
// CNT exists only when PRIORITY_DECODER_COUNT_EN is defined.
interface priority_decoder_if;

    logic W;
    logic Y;
    logic V;
    logic A;
    logic B;
    logic C;
    logic D;
    logic RDY;
    logic BUSY;
`ifdef PRIORITY_DECODER_COUNT_EN
    logic [7:0] CNT;

    modport master (
        output W, Y, V,
        input  A, B, C, D, RDY, BUSY, CNT
    );

    modport slave (
        input  W, Y, V,
        output A, B, C, D, RDY, BUSY, CNT
    );
`else
    modport master (
        output W, Y, V,
        input  A, B, C, D, RDY, BUSY
    );

    modport slave (
        input  W, Y, V,
        output A, B, C, D, RDY, BUSY
    );
`endif

endinterface

// File: rtl/priority_decoder_hold_counter.sv
// Hold-cycle down counter: load has priority, decrement stops at zero.
// The zero flag marks the last cycle of a hold pulse.
module hold_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    assign zero = (count == '0);

    // Load a new hold length or count down towards zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/priority_decoder.sv
// Priority decoder: accepts a 2-bit code and holds its one-hot output HOLD cycles.
// Optional accepted-code counter on bus CNT under PRIORITY_DECODER_COUNT_EN.
module priority_decoder
    import priority_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic          CLK,
    input  logic          RST,
    priority_decoder_if.slave bus
);

    localparam logic [HOLD_W-1:0] LOAD = HOLD_W'(HOLD - 1);

    state_t     state;
    logic [1:0] code;
    logic [3:0] onehot;
    logic       zero;
    logic       last;
    logic       accept;

    assign last    = (state == S_HOLD) && zero;
    assign bus.RDY = (state == S_IDLE) || last;
    assign accept  = bus.V && bus.RDY;

    assign {bus.A, bus.B, bus.C, bus.D} = onehot;

    hold_counter #(
        .WIDTH (HOLD_W)
    ) u_hold (
        .clk      (CLK),
        .rst      (RST),
        .load     (accept),
        .dec      (state == S_HOLD),
        .load_val (LOAD),
        .zero     (zero)
    );

    // FSM with registered one-hot outputs; an accept on the last cycle reloads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            code     <= CODE_D;
            onehot   <= 4'b0000;
            bus.BUSY <= 1'b0;
        end else if (accept) begin
            state    <= S_HOLD;
            code     <= {bus.W, bus.Y};
            onehot   <= decode({bus.W, bus.Y});
            bus.BUSY <= 1'b1;
        end else if (last) begin
            state    <= S_IDLE;
            onehot   <= 4'b0000;
            bus.BUSY <= 1'b0;
        end else if (state == S_HOLD) begin
            onehot   <= decode(code);
            bus.BUSY <= 1'b1;
        end
    end

`ifdef PRIORITY_DECODER_COUNT_EN
    logic [7:0] cnt;

    assign bus.CNT = cnt;

    // Saturating count of accepted codes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= 8'd0;
        end else if (accept && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Self-checking bench: HOLD=4 and HOLD=1 decoders driven by the same stimulus,
// checked each cycle against a timeline model plus literal directed checks.
module tb_priority_decoder;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    priority_decoder_if bus0 ();
    priority_decoder_if bus1 ();

    priority_decoder #(.HOLD(4)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    priority_decoder #(.HOLD(1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    int pass_n  = 0;
    int total_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: each accepted code owns cycles [start, end] of the cycle timeline.
    int hold_m [2] = '{4, 1};
    int start_m[2] = '{0, 0};
    int end_m  [2] = '{-1, -1};
    int code_m [2] = '{0, 0};
    int acc_m  [2] = '{0, 0};
    int cyc = 0;

    function automatic bit active_m(input int i);
        return (start_m[i] <= cyc) && (cyc <= end_m[i]);
    endfunction

    function automatic bit rdy_m(input int i);
        return !active_m(i) || (cyc == end_m[i]);
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                start_m[i] = 0;
                end_m[i]   = -1;
                acc_m[i]   = 0;
            end else if (bus0.V && rdy_m(i)) begin
                start_m[i] = cyc + 1;
                end_m[i]   = cyc + hold_m[i];
                code_m[i]  = {bus0.W, bus0.Y};
                acc_m[i]   = acc_m[i] + 1;
            end
        end
        cyc = cyc + 1;
    end

    logic [3:0] out_a[2];
    logic       busy_a[2];
    logic       rdy_a[2];
    assign out_a[0]  = {bus0.A, bus0.B, bus0.C, bus0.D};
    assign out_a[1]  = {bus1.A, bus1.B, bus1.C, bus1.D};
    assign busy_a[0] = bus0.BUSY;
    assign busy_a[1] = bus1.BUSY;
    assign rdy_a[0]  = bus0.RDY;
    assign rdy_a[1]  = bus1.RDY;

`ifdef PRIORITY_DECODER_COUNT_EN
    logic [7:0] cnt_a[2];
    assign cnt_a[0] = bus0.CNT;
    assign cnt_a[1] = bus1.CNT;
`endif

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            int  exp_o;
            bit  exp_b;
            bit  exp_r;
            int  exp_c;
            if (RST) begin
                exp_o = 0;
                exp_b = 1'b0;
                exp_r = 1'b1;
                exp_c = 0;
            end else begin
                exp_b = active_m(i);
                exp_o = exp_b ? (1 << code_m[i]) : 0;
                exp_r = rdy_m(i);
                exp_c = (acc_m[i] > 255) ? 255 : acc_m[i];
            end
            chk($sformatf("cyc_out%0d", i), int'(out_a[i]), exp_o);
            chk($sformatf("cyc_busy%0d", i), int'(busy_a[i]), int'(exp_b));
            chk($sformatf("cyc_rdy%0d", i), int'(rdy_a[i]), int'(exp_r));
            chk($sformatf("cyc_onehot%0d", i), int'($countones(out_a[i]) <= 1), 1);
`ifdef PRIORITY_DECODER_COUNT_EN
            chk($sformatf("cyc_cnt%0d", i), int'(cnt_a[i]), exp_c);
`endif
        end
    end

    task automatic drive(input bit v, input bit w, input bit y);
        bus0.V = v; bus0.W = w; bus0.Y = y;
        bus1.V = v; bus1.W = w; bus1.Y = y;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] stream_exp[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_out", int'(out_a[0]), 0);
        chk("reset_busy", int'(bus0.BUSY), 0);
        chk("reset_rdy", int'(bus0.RDY), 1);
        RST = 1'b0;

        // Single code 00 accepted on the first edge after reset release.
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("single_D", int'(bus0.D), int'(k < 4));
            chk("single_busy", int'(bus0.BUSY), int'(k < 4));
            tick();
        end

        // Back-to-back: 10 then 01 presented on the last hold cycle.
        drive(1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 9; k++) begin
            chk("b2b_B", int'(bus0.B), int'(k < 4));
            chk("b2b_C", int'(bus0.C), int'(k >= 4 && k < 8));
            if (k == 3) drive(1'b1, 1'b0, 1'b1);
            else drive(1'b0, 1'b0, 1'b0);
            tick();
        end

        // Code 11 offered while busy with counter > 0 is dropped.
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("ignore_A", int'(bus0.A), 0);
            chk("ignore_D", int'(bus0.D), int'(k < 4));
            if (k < 3) drive(1'b1, 1'b1, 1'b1);
            else drive(1'b0, 1'b0, 1'b0);
            tick();
        end

        // HOLD=1 stream: one new code per cycle, consecutive.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k[1], k[0]);
            tick();
            chk("stream1", int'(out_a[1]), int'(stream_exp[k]));
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("stream1_end", int'(out_a[1]), 0);

        // Asynchronous reset mid-hold on code 11.
        drive(1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("arst_pre_A", int'(bus0.A), 1);
        tick();
        #2;
        RST = 1'b1;
        #1;
        chk("arst_A", int'(bus0.A), 0);
        chk("arst_busy", int'(bus0.BUSY), 0);
        chk("arst_rdy", int'(bus0.RDY), 1);
        tick();
        RST = 1'b0;
        chk("arst_rel_rdy", int'(bus0.RDY), 1);
        chk("arst_rel_busy", int'(bus0.BUSY), 0);

`ifdef PRIORITY_DECODER_COUNT_EN
        drive(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("cnt_sat", int'(bus1.CNT), 255);
        RST = 1'b1;
        #1;
        chk("cnt_rst", int'(bus1.CNT), 0);
        tick();
        RST = 1'b0;
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom));
            RST = ($urandom_range(0, 99) == 0);
            tick();
        end
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (6) tick();

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
